// File: rtl/producto_escalar_pkg.sv
// Shared constants for the productoEscalar driver: FSM encoding, default widths
// and the wr_sel bank codes.
package producto_escalar_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_START  = 3'd1;
  localparam logic [STATE_W-1:0] S_STREAM = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE   = 3'd4;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_RES_W  = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Index width for an n-entry bank; a single-entry bank still needs one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/producto_escalar_driver_operand_bank.sv
// N x DATA_W operand register file: synchronous write, combinational read,
// asynchronous clear on active-low reset.
module operand_bank #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N];

  // Addresses past the last element (possible when N is not a power of two) are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < N)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < N) rdata = mem[raddr];
  end

endmodule

// File: rtl/producto_escalar_driver.sv
// Streaming initiator for the productoEscalar dot-product unit.
// Optional watchdog on the WAIT state: define PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN.
module producto_escalar_driver
  import producto_escalar_pkg::*;
#(
  parameter int N       = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int RES_W   = DEFAULT_RES_W,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [addr_width(N)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     go,
  output logic                     start,
  output logic                     valid,
  output logic [DATA_W-1:0]        a,
  output logic [DATA_W-1:0]        b,
  input  logic                     busy,
  input  logic [RES_W-1:0]         result,
  output logic [RES_W-1:0]         res_out,
  output logic                     done,
  output logic                     running
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam int AW = addr_width(N);
  localparam int CW = $clog2(N + 1);

  logic [STATE_W-1:0] state;
  logic [CW-1:0]      idx;
  logic               first_wait;
  logic [DATA_W-1:0]  rd_a;
  logic [DATA_W-1:0]  rd_b;
  logic               we_a;
  logic               we_b;

`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  // Banks only accept writes while idle so operands stay frozen during a run.
  assign we_a = wr_en && (state == S_IDLE) && (wr_sel == SEL_A);
  assign we_b = wr_en && (state == S_IDLE) && (wr_sel == SEL_B);

  operand_bank #(.N(N), .DATA_W(DATA_W), .AW(AW)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (we_a),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx[AW-1:0]),
    .rdata (rd_a)
  );

  operand_bank #(.N(N), .DATA_W(DATA_W), .AW(AW)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (we_b),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx[AW-1:0]),
    .rdata (rd_b)
  );

  // idx names the element loaded at the next edge; reaching N ends the stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      first_wait <= 1'b0;
      start      <= 1'b0;
      valid      <= 1'b0;
      a          <= '0;
      b          <= '0;
      res_out    <= '0;
      done       <= 1'b0;
      running    <= 1'b0;
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_START;
            start   <= 1'b1;
            running <= 1'b1;
            idx     <= '0;
          end
        end
        S_START: begin
          state <= S_STREAM;
          valid <= 1'b1;
          a     <= rd_a;
          b     <= rd_b;
          idx   <= CW'(1);
        end
        S_STREAM: begin
          if (idx == CW'(N)) begin
            state      <= S_WAIT;
            valid      <= 1'b0;
            a          <= '0;
            b          <= '0;
            idx        <= '0;
            first_wait <= 1'b1;
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end else begin
            a   <= rd_a;
            b   <= rd_b;
            idx <= idx + 1'b1;
          end
        end
        S_WAIT: begin
          // The consumer's busy may lag our last valid, so the first WAIT cycle never completes.
          first_wait <= 1'b0;
          if (!first_wait && !busy) begin
            res_out <= result;
            done    <= 1'b1;
            state   <= S_DONE;
          end
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          running <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          running <= 1'b0;
          valid   <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_producto_escalar_driver.sv
// Scoreboard bench for producto_escalar_driver with a behavioural productoEscalar consumer.
// Exercises the watchdog path when PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN is defined.
module tb_producto_escalar_driver;
  import producto_escalar_pkg::*;

  localparam int N       = 4;
  localparam int DATA_W  = 8;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int AW      = 2;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              go;
  logic              start;
  logic              valid;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic [RES_W-1:0]  result;
  logic [RES_W-1:0]  res_out;
  logic              done;
  logic              running;
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
  logic              timeout;
`endif

  int tests_run  = 0;
  int fail_count = 0;

  producto_escalar_driver #(
    .N(N), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .go      (go),
    .start   (start),
    .valid   (valid),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .result  (result),
    .res_out (res_out),
    .done    (done),
    .running (running)
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural consumer: accumulates a*b while valid, then holds busy for hold_cycles.
  int               hold_cycles = 0;
  bit               stuck_busy  = 1'b0;
  logic [RES_W-1:0] acc;
  int               phase;
  int               hold_left;
  logic             prev_valid_c;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      acc          <= '0;
      phase        <= 0;
      hold_left    <= 0;
      prev_valid_c <= 1'b0;
    end else begin
      prev_valid_c <= valid;
      case (phase)
        0: if (start) begin
          acc   <= '0;
          busy  <= 1'b1;
          phase <= 1;
        end
        1: begin
          if (valid) acc <= acc + RES_W'(a) * RES_W'(b);
          else if (prev_valid_c) begin
            if (stuck_busy) phase <= 3;
            else if (hold_cycles == 0) begin
              busy  <= 1'b0;
              phase <= 0;
            end else begin
              hold_left <= hold_cycles - 1;
              phase     <= 2;
            end
          end
        end
        2: begin
          if (hold_left == 0) begin
            busy  <= 1'b0;
            phase <= 0;
          end else hold_left <= hold_left - 1;
        end
        default: ;
      endcase
    end
  end
  assign result = acc;

  // Scoreboard queues and bench-side operand model
  logic [2*DATA_W-1:0] exp_pairs[$];
  logic [RES_W-1:0]    exp_res[$];
  bit                  exp_to[$];
  logic [DATA_W-1:0]   model_a[N];
  logic [DATA_W-1:0]   model_b[N];
  logic [RES_W-1:0]    last_res = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Output monitor, sampled on the falling edge
  int start_cyc      = -100;
  int start_count    = 0;
  int last_valid_cyc = -100;
  int busy_fall_cyc  = -100;
  bit prev_valid_m   = 1'b0;
  bit prev_busy_m    = 1'b0;
  bit to_exp;

  always @(negedge clk) begin
    if (reset) begin
      if (start) begin
        start_cyc = cyc;
        start_count++;
        checkOutput("start_no_valid", {31'd0, valid}, 32'd0);
      end
      if (valid) begin
        if (!prev_valid_m) checkOutput("first_valid_cycle", cyc, start_cyc + 1);
        if (exp_pairs.size() == 0) checkOutput("pair_unexpected", 32'd1, 32'd0);
        else checkOutput("ab_pair", {16'd0, a, b}, {16'd0, exp_pairs.pop_front()});
        last_valid_cyc = cyc;
      end
      if (prev_busy_m && !busy) busy_fall_cyc = cyc;
      if (done) begin
        if (exp_res.size() == 0) checkOutput("done_unexpected", 32'd1, 32'd0);
        else begin
          to_exp = exp_to.pop_front();
          checkOutput("res_out", {16'd0, res_out}, {16'd0, exp_res.pop_front()});
          if (to_exp) checkOutput("timeout_latency", cyc, last_valid_cyc + TIMEOUT + 1);
          else checkOutput("done_after_busy", cyc, busy_fall_cyc + 1);
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
          checkOutput("timeout_flag", {31'd0, timeout}, {31'd0, to_exp});
`endif
        end
      end
      prev_valid_m = valid;
      prev_busy_m  = busy;
    end else begin
      prev_valid_m = 1'b0;
      prev_busy_m  = 1'b0;
    end
  end

  task automatic writeElem(input logic sel, input int addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel == SEL_A) model_a[addr] = data;
    else model_b[addr] = data;
  endtask

  // Queues expectations, pulses go, optionally disturbs the run, waits for done.
  task automatic applyStimulus(input bit disturb, input bit expect_timeout);
    int sum;
    int running_low;
    bit seen;
    logic [RES_W-1:0] er;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      exp_pairs.push_back({model_a[i], model_b[i]});
      sum += int'(model_a[i]) * int'(model_b[i]);
    end
    er = expect_timeout ? last_res : RES_W'(sum);
    last_res = er;
    exp_res.push_back(er);
    exp_to.push_back(expect_timeout);
    busy_fall_cyc = -100;
    running_low = 0;
    seen = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      if (!running) running_low++;
      if (done) seen = 1'b1;
      else begin
        if (disturb && t == 1) begin
          go      = 1'b1;
          wr_en   = 1'b1;
          wr_sel  = SEL_A;
          wr_addr = '0;
          wr_data = 8'd99;
        end else begin
          go    = 1'b0;
          wr_en = 1'b0;
        end
        @(negedge clk);
      end
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    checkOutput("running_held", running_low, 0);
    @(negedge clk);
    checkOutput("done_single", {31'd0, done}, 32'd0);
    checkOutput("idle_running", {31'd0, running}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int starts_before;
    int done_during_reset;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = SEL_A;
    wr_addr = '0;
    wr_data = '0;
    go      = 1'b0;
    for (int i = 0; i < N; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_start", {31'd0, start}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_running", {31'd0, running}, 32'd0);
    checkOutput("rst_ab", {16'd0, a, b}, 32'd0);
    checkOutput("rst_res_out", {16'd0, res_out}, 32'd0);
`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] basic run A={3,5,7,9} B={4,6,8,10}");
    for (int i = 0; i < N; i++) begin
      writeElem(SEL_A, i, DATA_W'(3 + 2 * i));
      writeElem(SEL_B, i, DATA_W'(4 + 2 * i));
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("res_188", {16'd0, res_out}, 32'd188);

    $display("[TB] all-255 wraparound");
    for (int i = 0; i < N; i++) begin
      writeElem(SEL_A, i, 8'd255);
      writeElem(SEL_B, i, 8'd255);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("res_63492", {16'd0, res_out}, 32'd63492);

    $display("[TB] consumer holds busy 10 cycles");
    hold_cycles = 10;
    applyStimulus(1'b0, 1'b0);
    hold_cycles = 0;

    $display("[TB] go and write during STREAM are ignored");
    for (int i = 0; i < N; i++) begin
      writeElem(SEL_A, i, DATA_W'(3 + 2 * i));
      writeElem(SEL_B, i, DATA_W'(4 + 2 * i));
    end
    starts_before = start_count;
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_start", start_count - starts_before, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rerun_188", {16'd0, res_out}, 32'd188);

`ifdef PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN
    $display("[TB] busy stuck high, watchdog");
    stuck_busy = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("res_kept", {16'd0, res_out}, 32'd188);
    stuck_busy = 1'b0;
`endif

    $display("[TB] reset during third STREAM cycle");
    for (int i = 0; i < N; i++) exp_pairs.push_back({model_a[i], model_b[i]});
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_start", {31'd0, start}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("mid_rst_running", {31'd0, running}, 32'd0);
    checkOutput("mid_rst_res_out", {16'd0, res_out}, 32'd0);
    done_during_reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_during_reset++;
    end
    checkOutput("mid_rst_no_done", done_during_reset, 0);
    exp_pairs.delete();
    exp_res.delete();
    exp_to.delete();
    for (int i = 0; i < N; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    checkOutput("zero_run_res", {16'd0, res_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/producto_escalar_driver.md
Name: producto_escalar_driver

Overview:
Streaming initiator for the productoEscalar dot-product unit; it is the producer that drives that unit's start/valid/a/b interface.
- Holds two N-element operand vectors loaded through a simple write port.
- On a go pulse: issues start, streams the element pairs one per cycle, waits for the consumer's busy to fall, then captures result.
- Sits between the host/register side and the productoEscalar unit, replacing hand-written bench stimulus in system builds.

Parameters:
- N, 4: elements per vector (≥2).
- DATA_W, 8: width of a, b elements.
- RES_W, 16: width of consumer result.
- TIMEOUT, 64: watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = vector A, 1 = vector B.
- wr_addr  in  clog2(N)  element index.
- wr_data  in  DATA_W  element value.
- go  in  1  one-cycle request to run a dot product.
- start  out  1  to consumer, one-cycle pulse.
- valid  out  1  to consumer, qualifies a/b.
- a  out  DATA_W  to consumer.
- b  out  DATA_W  to consumer.
- busy  in  1  from consumer.
- result  in  RES_W  from consumer.
- res_out  out  RES_W  captured result, held until next capture.
- done  out  1  one-cycle pulse when res_out updates.
- running  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE; start=valid=done=running=0; a=b=0; res_out=0; index=0; operand banks cleared to 0.
- FSM states: IDLE, START, STREAM, WAIT, DONE. All outputs are registered.
- IDLE:
  - wr_en writes the bank selected by wr_sel at wr_addr.
  - go=1 → START on the next edge.
  - go and wr_en in the same cycle: the write completes, then go takes effect.
- START: one cycle with start=1, valid=0, a=b=0 → STREAM.
- STREAM: N consecutive cycles with valid=1 and a=A[i], b=B[i], i=0..N-1.
  - After i=N-1 → WAIT; valid drops to 0 and a, b return to 0.
- WAIT:
  - Spend at least one full cycle in WAIT; busy is ignored in that first cycle.
  - Then on the first sampled busy=0: capture result into res_out → DONE.
- DONE: done=1 for one cycle → IDLE.
- Latency: go sampled at edge k gives start high in cycle k+1, valid in cycles k+2..k+N+1, and done no earlier than k+N+3.
- Ignored inputs:
  - go while not in IDLE has no effect and is not queued.
  - wr_en while not in IDLE is ignored; the banks are stable during a run.
  - wr_addr ≥ N (non-power-of-2 N) is ignored.
- Arithmetic: the block performs none; result is captured bit-exact with no width change.
- Reset mid-operation: immediate return to IDLE; start and valid drop asynchronously; banks are cleared; no done is produced.

Optional Feature:
- PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN defined:
  - Adds output port timeout (1 bit) and a WAIT cycle counter.
  - If busy stays 1 for TIMEOUT cycles in WAIT: go to DONE, leave res_out unchanged, and pulse done and timeout together for one cycle.
  - timeout resets to 0.
- Not defined: no port, no counter; WAIT can last indefinitely.

Decomposition:
- Package producto_escalar_pkg holds:
  - State encoding constants (IDLE=0, START=1, STREAM=2, WAIT=3, DONE=4) and the state width.
  - Default DATA_W and RES_W, shared with productoEscalar.
  - SEL_A and SEL_B constants for wr_sel.
- One sub-module, operand_bank: an N×DATA_W register file with synchronous write, combinational read, and async clear. Instantiated twice (A, B).

Test Plan:
- Load A={3,5,7,9}, B={4,6,8,10}, pulse go, with a behavioural consumer → a/b pairs (3,4),(5,6),(7,8),(9,10) on consecutive valid cycles; start exactly one cycle before the first valid; res_out=188 with done one cycle.
- Load all elements 255 with RES_W=16 → res_out=63492 (260100 mod 2^16, passed through unmodified).
- Consumer holds busy=1 for 10 cycles after the last valid → done does not assert until the cycle after busy falls; running=1 throughout.
- go pulsed again during STREAM, and wr_en to A[0]=99 during STREAM → no second start, A[0] unchanged; after done, a rerun gives the same 188.
- reset=0 asserted during the third STREAM cycle → start=valid=0 immediately, no done; after release, banks read 0 and a run gives res_out from an all-zero stream.
- With PRODUCTO_ESCALAR_DRIVER_TIMEOUT_EN, TIMEOUT=8, busy stuck at 1 → done and timeout pulse together 8 cycles into WAIT; res_out keeps its previous value.
